// File: rtl/rv32_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// divider FSM states and the signed-overflow dividend.
package rv32_mdu_pkg;

  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [DIV_W-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift {rem, quo} left by one, then subtract
// the divisor from the partial remainder when it fits.
module div_restore_step
  import rv32_mdu_pkg::*;
(
  input  logic [DIV_W:0]   rem_i,
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] dvs_i,
  output logic [DIV_W:0]   rem_o,
  output logic [DIV_W-1:0] quo_o
);

  localparam int unsigned SH_W = DIV_W + 2;

  logic [SH_W-1:0] rem_sh;
  logic [SH_W-1:0] dvs_ext;
  logic            fits;

  always_comb begin
    rem_sh  = {rem_i, quo_i[DIV_W-1]};
    dvs_ext = {2'b00, dvs_i};
    fits    = (rem_sh >= dvs_ext);
    rem_o   = fits ? (DIV_W+1)'(rem_sh - dvs_ext) : (DIV_W+1)'(rem_sh);
    quo_o   = {quo_i[DIV_W-2:0], fits};
  end

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU with valid/ready
// handshakes; special cases finish in one cycle, the rest take 32 steps.
module mdu_div_iter
  import rv32_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             sel_rem_q, sel_rem_d;
  logic [DIV_W-1:0] result_q, result_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [DIV_W:0]   step_rem;
  logic [DIV_W-1:0] step_quo;
  logic [DIV_W-1:0] quo_fix, rem_fix;
  logic             is_signed;

  div_restore_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;
    is_signed = !funct3[0];
    quo_fix   = neg_quo_q ? DIV_W'(~step_quo + 32'd1) : step_quo;
    rem_fix   = neg_rem_q ? DIV_W'(~step_rem[DIV_W-1:0] + 32'd1) : step_rem[DIV_W-1:0];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!funct3[2]) begin
            state_d  = DONE;
            result_d = '0;
          end else if (rs2 == '0) begin
            state_d  = DONE;
            result_d = funct3[1] ? rs1 : '1;
          end else if (is_signed && rs1 == DIV_OVF_DIVIDEND && rs2 == '1) begin
            state_d  = DONE;
            result_d = funct3[1] ? '0 : DIV_OVF_DIVIDEND;
          end else begin
            // Iterate on magnitudes; signs are reapplied on the final step.
            state_d   = CALC;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = (is_signed && rs1[DIV_W-1]) ? DIV_W'(~rs1 + 32'd1) : rs1;
            dvs_d     = (is_signed && rs2[DIV_W-1]) ? DIV_W'(~rs2 + 32'd1) : rs2;
            neg_quo_d = is_signed && (rs1[DIV_W-1] ^ rs2[DIV_W-1]);
            neg_rem_d = is_signed && rs1[DIV_W-1];
            sel_rem_d = funct3[1];
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = CNT_W'(cnt_q + 6'd1);
        if (cnt_q == 6'd31) begin
          state_d  = DONE;
          result_d = sel_rem_q ? rem_fix : quo_fix;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      sel_rem_q   <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      sel_rem_q   <= sel_rem_d;
      result_q    <= result_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == CALC) || (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_div_iter.sv
// Self-checking bench for mdu_div_iter: directed divide/remainder vectors,
// latency, backpressure, flush and asynchronous reset behaviour.
module tb_mdu_div_iter;
  import rv32_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_res = '0;
  bit          armed = 1'b0;

  mdu_div_iter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Architectural RV32M divide/remainder semantics.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (!f3[2]) return 32'd0;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  // Whenever the unit is out of reset: result must match the pending
  // expectation while valid, and no result may appear unannounced.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_vs_busy", 32'(in_ready), 32'(!busy));
      if (!armed) check("no_spurious_valid", 32'(out_valid), 32'd0);
      else if (out_valid) check("result", result, exp_res);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int hold);
    bit special;
    int n;
    check({nm, "_model"}, model(f3, a, b), lit);
    special = !f3[2] || (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_res = lit;
    armed   = 1'b1;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      rs1 = $urandom;
      rs2 = $urandom;
      funct3 = 3'($urandom);
      n++;
    end while (!out_valid && n < 100);
    check({nm, "_latency"}, 32'(n), special ? 32'd1 : 32'd33);
    for (int i = 0; i < hold; i++) begin
      funct3   = F3_DIVU;
      rs1      = 32'd9;
      rs2      = 32'd3;
      in_valid = 1'b1;
      check({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    armed = 1'b0;
    check({nm, "_after_valid"}, 32'(out_valid), 32'd0);
    check({nm, "_after_ready"}, 32'(in_ready), 32'd1);
    check({nm, "_after_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("div_m7_2",   F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",   F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("div_5_0",    F3_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_5_0",    F3_REM,  32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf",    F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",    F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_ovf",   F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("rem_7_m2",   F3_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 0);
    run_op("div_m8_m3",  F3_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 0);
    run_op("remu_big_3", F3_REMU, 32'h8000_0000, 32'd3, 32'd2, 0);
    run_op("divu_max_1", F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("not_div",    3'b000,  32'd100, 32'd7, 32'd0, 0);

    // Backpressure in DONE for 10 cycles.
    run_op("bp_divu",    F3_DIVU, 32'd100, 32'd7, 32'd14, 10);

    // Flush while the counter reads 15.
    funct3 = F3_DIVU; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    run_op("post_flush", F3_DIVU, 32'd9, 32'd3, 32'd3, 0);

    // Flush together with a request in IDLE: nothing is accepted.
    funct3 = F3_DIV; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", 32'(in_ready), 32'd1);
    check("flush_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-CALC.
    funct3 = F3_DIVU; rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    run_op("post_rst", F3_DIVU, 32'd1000, 32'd3, 32'd333, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
